display_list_builder: RTL and testbench
=======================================

Name: display_list_builder

Overview:
- Parametrised successor to the fixed frame/map/cursor/enemy memory manager.
- Builds one vector display list per frame request. Walks a table of N_OBJ sprite objects, fetches each object's point list from ROM, translates it to the object's screen position, clamps it to the frame window and writes it to the display RAM read by the bresenham line drawer.
- Adds a start/busy/done handshake, snapshotting of object inputs, clamping, configurable ROM latency and RAM overflow protection.

Parameters:
- OUT_WIDTH, 8: coordinate width.
- ADR_WIDTH, 16: ROM and RAM address width.
- DATAWIDTH, 18: vector word width; must equal 2*OUT_WIDTH+2.
- N_OBJ, 4: number of object slots (frame, map, cursor and enemies are all slots).
- RAM_DEPTH, 1024: display RAM words, ≥2.
- FRAME_MIN, 0: lowest legal coordinate.
- FRAME_MAX, 255: highest legal coordinate.
- ROM_LATENCY, 1: cycles from adrROM change to valid dataROM, ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  build request, sampled only in IDLE
- busy  out  1  build in progress
- done  out  1  one-cycle pulse after tail word written
- overflow  out  1  sticky: list truncated by RAM_DEPTH; cleared on accepted start
- word_count  out  ADR_WIDTH  words written in last build, header and tail included
- obj_en  in  N_OBJ  per-slot enable
- obj_adr  in  N_OBJ*ADR_WIDTH  ROM start address per slot (slot i at [i*ADR_WIDTH +: ADR_WIDTH])
- obj_x, obj_y  in  N_OBJ*OUT_WIDTH each  screen position per slot
- obj_mid_x, obj_mid_y  in  N_OBJ*OUT_WIDTH each  sprite anchor per slot (0 for absolute images)
- adrROM  out  ADR_WIDTH  ROM read address
- dataROM  in  DATAWIDTH  ROM data
- adrWRITE  out  ADR_WIDTH  RAM write address
- dataWRITE  out  DATAWIDTH  RAM write data
- weWRITE  out  1  RAM write strobe

Behaviour:
- Word format: x=[DATAWIDTH-1:OUT_WIDTH+2], y=[OUT_WIDTH+1:2], line=[1], pos=[0]. Terminator is line&pos=1.
- Reset: state IDLE. busy, done, overflow, weWRITE, adrROM, adrWRITE, dataWRITE and word_count are all 0. A reset mid-build aborts immediately with no further writes.
- All outputs are registered. weWRITE is high only in cycles presenting a valid word.
- States:
  - IDLE: if start, snapshot all obj_* inputs, clear overflow, set busy, go to HEADER. Start while busy is ignored.
  - HEADER: write {0,0,0,1} at adr 0; slot index=0; go to SELECT.
  - SELECT (one cycle per slot): if index==N_OBJ go to TAIL. Else if obj_en[index]=0, increment index. Else load adrROM=obj_adr[index] and go to FETCH.
  - FETCH: wait ROM_LATENCY cycles, then go to EVAL.
  - EVAL on a terminator: nothing is written; index+1 and go to SELECT.
  - EVAL on a non-terminator: compute x'=xROM-mid_x+obj_x and y' likewise, in signed OUT_WIDTH+2 bits. Clamp each to [FRAME_MIN,FRAME_MAX]. Write {x',y',line,pos} at the next address, adrROM+1, go to FETCH.
  - EVAL when the next write address would be RAM_DEPTH-1: set overflow, write nothing more, go to TAIL.
  - TAIL: write {0,0,1,1} at the next address (≤RAM_DEPTH-1); latch word_count = tail address+1; go to DONE.
  - DONE: pulse done, clear busy, go to IDLE.
- Throughput: one word per ROM_LATENCY+1 cycles.
- adrROM wraps at 2^ADR_WIDTH. Coordinates never wrap; they are clamped.
- Changes to obj_* inputs during a build have no effect on that build.

Test Plan:
- All obj_en=0, start pulse → {0,0,0,1}@0, {0,0,1,1}@1, exactly 2 we strobes, one done pulse, word_count=2, overflow=0.
- Slot 0 enabled, ROM@0x10 = (10,20,0,1),(30,20,1,0),terminator; obj_x=100, obj_y=100, mid=(8,8) → (102,112,0,1)@1, (122,112,1,0)@2, tail@3, word_count=4.
- Clamp: obj_x=250, ROM x=20, mid_x=8 → written x=255. obj_x=2, ROM x=0, mid_x=8 → x=0. Repeat with FRAME_MIN=16, FRAME_MAX=200 → x=200 and x=16.
- Overflow: RAM_DEPTH=8, one slot with 10 points → points @1..6, tail @7, overflow=1, word_count=8; next start clears overflow.
- Snapshot/handshake: change obj_x from 100 to 50 and pulse start again mid-build → every word uses 100, second start ignored, single done; ROM_LATENCY=3 gives 4 cycles between strobes.
- Reset mid-build: assert rst during slot 1 → next cycle weWRITE=0, busy=0, all outputs 0; a following start produces a complete correct list.

Source files
------------

// File: rtl/display_list_builder_if.sv
// Bus bundle for display_list_builder: build handshake, object table, ROM read and RAM write ports.
interface display_list_builder_if #(
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned ADR_WIDTH = 16,
  parameter int unsigned DATAWIDTH = 18,
  parameter int unsigned N_OBJ     = 4
);
  logic                           start;
  logic                           busy;
  logic                           done;
  logic                           overflow;
  logic [ADR_WIDTH-1:0]           word_count;
  logic [N_OBJ-1:0]               obj_en;
  logic [N_OBJ*ADR_WIDTH-1:0]     obj_adr;
  logic [N_OBJ*OUT_WIDTH-1:0]     obj_x;
  logic [N_OBJ*OUT_WIDTH-1:0]     obj_y;
  logic [N_OBJ*OUT_WIDTH-1:0]     obj_mid_x;
  logic [N_OBJ*OUT_WIDTH-1:0]     obj_mid_y;
  logic [ADR_WIDTH-1:0]           adrROM;
  logic [DATAWIDTH-1:0]           dataROM;
  logic [ADR_WIDTH-1:0]           adrWRITE;
  logic [DATAWIDTH-1:0]           dataWRITE;
  logic                           weWRITE;

  // Builder side: consumes requests/object table/ROM data, drives status, ROM address and RAM writes.
  modport master (
    input  start, obj_en, obj_adr, obj_x, obj_y, obj_mid_x, obj_mid_y, dataROM,
    output busy, done, overflow, word_count, adrROM, adrWRITE, dataWRITE, weWRITE
  );

  modport slave (
    output start, obj_en, obj_adr, obj_x, obj_y, obj_mid_x, obj_mid_y, dataROM,
    input  busy, done, overflow, word_count, adrROM, adrWRITE, dataWRITE, weWRITE
  );
endinterface

// File: rtl/display_list_builder.sv
// Builds one vector display list per start request: walks the object slots, translates and clamps
// each ROM point to the frame window and writes header, points and tail into display RAM.
module display_list_builder #(
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned ADR_WIDTH   = 16,
  parameter int unsigned DATAWIDTH   = 18,
  parameter int unsigned N_OBJ       = 4,
  parameter int unsigned RAM_DEPTH   = 1024,
  parameter int          FRAME_MIN   = 0,
  parameter int          FRAME_MAX   = 255,
  parameter int unsigned ROM_LATENCY = 1
) (
  input logic                    clk,
  input logic                    rst,
  display_list_builder_if.master bus
);
  localparam int unsigned CW    = OUT_WIDTH + 2;
  localparam int unsigned IDX_W = $clog2(N_OBJ + 1);
  localparam int unsigned LAT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam int unsigned AW_T  = N_OBJ * ADR_WIDTH;
  localparam int unsigned OW_T  = N_OBJ * OUT_WIDTH;
  localparam logic signed [CW-1:0] LO_S = CW'(FRAME_MIN);
  localparam logic signed [CW-1:0] HI_S = CW'(FRAME_MAX);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_SELECT, S_FETCH, S_EVAL, S_TAIL, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, we_q, we_d;
  logic [ADR_WIDTH-1:0]   adr_rom_q, adr_rom_d, adr_wr_q, adr_wr_d;
  logic [ADR_WIDTH-1:0]   nxt_q, nxt_d, wc_q, wc_d;
  logic [DATAWIDTH-1:0]   data_wr_q, data_wr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic [N_OBJ-1:0]       en_q, en_d;
  logic [AW_T-1:0]        sadr_q, sadr_d;
  logic [OW_T-1:0]        sx_q, sx_d, sy_q, sy_d, smx_q, smx_d, smy_q, smy_d;

  logic                   cur_en;
  logic [ADR_WIDTH-1:0]   cur_adr;
  logic [OUT_WIDTH-1:0]   cur_x, cur_y, cur_mx, cur_my;
  logic [OUT_WIDTH-1:0]   rom_x, rom_y;
  logic                   rom_line, rom_pos;

  assign rom_x    = bus.dataROM[DATAWIDTH-1 -: OUT_WIDTH];
  assign rom_y    = bus.dataROM[OUT_WIDTH+1 -: OUT_WIDTH];
  assign rom_line = bus.dataROM[1];
  assign rom_pos  = bus.dataROM[0];

  // Translate by (pos - anchor) in widened signed arithmetic, then clamp to the frame window.
  function automatic logic [OUT_WIDTH-1:0] place(input logic [OUT_WIDTH-1:0] p_rom,
                                                 input logic [OUT_WIDTH-1:0] p_mid,
                                                 input logic [OUT_WIDTH-1:0] p_pos);
    logic signed [CW-1:0] v;
    v = $signed({2'b00, p_rom}) - $signed({2'b00, p_mid}) + $signed({2'b00, p_pos});
    if (v < LO_S) return OUT_WIDTH'(FRAME_MIN);
    if (v > HI_S) return OUT_WIDTH'(FRAME_MAX);
    return v[OUT_WIDTH-1:0];
  endfunction

  // Current slot select from the snapshot.
  always_comb begin
    cur_en  = 1'b0;
    cur_adr = '0;
    cur_x   = '0;
    cur_y   = '0;
    cur_mx  = '0;
    cur_my  = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_en  = en_q[i];
        cur_adr = sadr_q[i*ADR_WIDTH +: ADR_WIDTH];
        cur_x   = sx_q[i*OUT_WIDTH +: OUT_WIDTH];
        cur_y   = sy_q[i*OUT_WIDTH +: OUT_WIDTH];
        cur_mx  = smx_q[i*OUT_WIDTH +: OUT_WIDTH];
        cur_my  = smy_q[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    we_d      = 1'b0;
    adr_rom_d = adr_rom_q;
    adr_wr_d  = adr_wr_q;
    data_wr_d = data_wr_q;
    nxt_d     = nxt_q;
    wc_d      = wc_q;
    idx_d     = idx_q;
    lat_d     = lat_q;
    en_d      = en_q;
    sadr_d    = sadr_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    smx_d     = smx_q;
    smy_d     = smy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          en_d    = bus.obj_en;
          sadr_d  = bus.obj_adr;
          sx_d    = bus.obj_x;
          sy_d    = bus.obj_y;
          smx_d   = bus.obj_mid_x;
          smy_d   = bus.obj_mid_y;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        we_d      = 1'b1;
        adr_wr_d  = '0;
        data_wr_d = DATAWIDTH'(1);
        nxt_d     = ADR_WIDTH'(1);
        idx_d     = '0;
        state_d   = S_SELECT;
      end
      S_SELECT: begin
        if (idx_q == IDX_W'(N_OBJ)) begin
          state_d = S_TAIL;
        end else if (!cur_en) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          adr_rom_d = cur_adr;
          lat_d     = '0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        if (lat_q == LAT_W'(ROM_LATENCY - 1)) state_d = S_EVAL;
        else                                  lat_d   = lat_q + LAT_W'(1);
      end
      S_EVAL: begin
        if (rom_line && rom_pos) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_SELECT;
        end else if (nxt_q == ADR_WIDTH'(RAM_DEPTH - 1)) begin
          // Last RAM word is reserved for the tail.
          ovf_d   = 1'b1;
          state_d = S_TAIL;
        end else begin
          we_d      = 1'b1;
          adr_wr_d  = nxt_q;
          data_wr_d = {place(rom_x, cur_mx, cur_x), place(rom_y, cur_my, cur_y), rom_line, rom_pos};
          nxt_d     = nxt_q + ADR_WIDTH'(1);
          adr_rom_d = adr_rom_q + ADR_WIDTH'(1);
          lat_d     = '0;
          state_d   = S_FETCH;
        end
      end
      S_TAIL: begin
        we_d      = 1'b1;
        adr_wr_d  = nxt_q;
        data_wr_d = DATAWIDTH'(3);
        wc_d      = nxt_q + ADR_WIDTH'(1);
        state_d   = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_rom_q <= '0;
      adr_wr_q  <= '0;
      data_wr_q <= '0;
      nxt_q     <= '0;
      wc_q      <= '0;
      idx_q     <= '0;
      lat_q     <= '0;
      en_q      <= '0;
      sadr_q    <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      smx_q     <= '0;
      smy_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      we_q      <= we_d;
      adr_rom_q <= adr_rom_d;
      adr_wr_q  <= adr_wr_d;
      data_wr_q <= data_wr_d;
      nxt_q     <= nxt_d;
      wc_q      <= wc_d;
      idx_q     <= idx_d;
      lat_q     <= lat_d;
      en_q      <= en_d;
      sadr_q    <= sadr_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      smx_q     <= smx_d;
      smy_q     <= smy_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overflow   = ovf_q;
  assign bus.word_count = wc_q;
  assign bus.adrROM     = adr_rom_q;
  assign bus.adrWRITE   = adr_wr_q;
  assign bus.dataWRITE  = data_wr_q;
  assign bus.weWRITE    = we_q;
endmodule

// File: tb/tb_display_list_builder.sv
// Bench for display_list_builder: default instance u0 and a narrow-frame, 8-word RAM, 3-cycle ROM instance u1.
module tb_display_list_builder;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  display_list_builder_if #(.OUT_WIDTH(8), .ADR_WIDTH(16), .DATAWIDTH(18), .N_OBJ(4)) b0 ();
  display_list_builder_if #(.OUT_WIDTH(8), .ADR_WIDTH(16), .DATAWIDTH(18), .N_OBJ(4)) b1 ();

  display_list_builder u0 (.clk(clk), .rst(rst), .bus(b0));
  display_list_builder #(.RAM_DEPTH(8), .FRAME_MIN(16), .FRAME_MAX(200), .ROM_LATENCY(3))
    u1 (.clk(clk), .rst(rst), .bus(b1));

  logic [17:0] rom [256];
  logic [17:0] rd0;
  logic [17:0] rd1 [3];
  always @(posedge clk) rd0 <= rom[b0.adrROM[7:0]];
  always @(posedge clk) begin
    rd1[0] <= rom[b1.adrROM[7:0]];
    rd1[1] <= rd1[0];
    rd1[2] <= rd1[1];
  end
  assign b0.dataROM = rd0;
  assign b1.dataROM = rd1[2];

  typedef struct {
    logic [15:0] adr;
    logic [17:0] data;
    int          cy;
  } wr_t;
  wr_t wlog0[$];
  wr_t wlog1[$];
  int  done0 = 0;
  int  done1 = 0;

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (b0.weWRITE) wlog0.push_back('{b0.adrWRITE, b0.dataWRITE, cyc});
    if (b1.weWRITE) wlog1.push_back('{b1.adrWRITE, b1.dataWRITE, cyc});
    if (b0.done) done0++;
    if (b1.done) done1++;
  end

  typedef struct {
    int              inst;
    logic [3:0]      en;
    logic [3:0][15:0] adr;
    logic [7:0]      x, y, mx, my;
    int              wc;
    int              npts;
    logic [1:0][17:0] pt;
  } vec_t;

  function automatic logic [17:0] w(input int x, input int y, input int l, input int p);
    return {8'(x), 8'(y), 1'(l), 1'(p)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int log_size(input int i);
    return (i == 0) ? wlog0.size() : wlog1.size();
  endfunction
  function automatic wr_t log_at(input int i, input int k);
    return (i == 0) ? wlog0[k] : wlog1[k];
  endfunction
  function automatic int done_cnt(input int i);
    return (i == 0) ? done0 : done1;
  endfunction

  task automatic chk_word(input int i, input int k, input int exp_adr, input logic [17:0] exp_data,
                          input string nm);
    wr_t e;
    if (k < log_size(i)) begin
      e = log_at(i, k);
      chk({nm, "_adr"}, 32'(e.adr), 32'(exp_adr));
      chk({nm, "_data"}, 32'(e.data), 32'(exp_data));
    end else begin
      chk({nm, "_missing"}, 32'(log_size(i)), 32'(k + 1));
    end
  endtask

  task automatic set_obj(input int i, input logic [3:0] en, input logic [63:0] adr,
                         input logic [7:0] x, input logic [7:0] y, input logic [7:0] mx, input logic [7:0] my);
    if (i == 0) begin
      b0.obj_en = en; b0.obj_adr = adr; b0.obj_x = {4{x}}; b0.obj_y = {4{y}};
      b0.obj_mid_x = {4{mx}}; b0.obj_mid_y = {4{my}};
    end else begin
      b1.obj_en = en; b1.obj_adr = adr; b1.obj_x = {4{x}}; b1.obj_y = {4{y}};
      b1.obj_mid_x = {4{mx}}; b1.obj_mid_y = {4{my}};
    end
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk);
    if (i == 0) b0.start = 1'b1; else b1.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    b1.start = 1'b0;
  endtask

  task automatic wait_done(input int i, input string nm);
    int n = 0;
    while (!((i == 0) ? b0.done : b1.done) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_seen"}, 32'(n < 3000), 32'd1);
  endtask

  // Full build: checks done count, strobe count, word_count, header and tail; returns log base.
  task automatic run_build(input int i, input string nm, input int exp_wc, output int base);
    int d;
    base = log_size(i);
    d    = done_cnt(i);
    pulse_start(i);
    wait_done(i, nm);
    repeat (4) @(negedge clk);
    chk({nm, "_done_cnt"}, 32'(done_cnt(i) - d), 32'd1);
    chk({nm, "_strobes"}, 32'(log_size(i) - base), 32'(exp_wc));
    chk({nm, "_wc"}, 32'((i == 0) ? b0.word_count : b1.word_count), 32'(exp_wc));
    chk({nm, "_busy"}, 32'((i == 0) ? b0.busy : b1.busy), 32'd0);
    chk_word(i, base, 0, 18'h1, {nm, "_hdr"});
    chk_word(i, base + exp_wc - 1, exp_wc - 1, 18'h3, {nm, "_tail"});
  endtask

  vec_t vecs[8];
  int   base;
  int   n;

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 18'h3;
    rom[8'h10] = w(10, 20, 0, 1);
    rom[8'h11] = w(30, 20, 1, 0);
    rom[8'h20] = w(20, 0, 0, 1);
    rom[8'h30] = w(0, 0, 0, 1);
    for (int k = 0; k < 10; k++) rom[8'h40 + k] = w(10 * k, 5 * k, 1, 0);

    vecs[0] = '{0, 4'b0000, 64'h0, 8'd0, 8'd0, 8'd0, 8'd0, 2, 0, 36'h0};
    vecs[1] = '{0, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h10}, 8'd100, 8'd100, 8'd8, 8'd8, 4, 2,
                {w(122, 112, 1, 0), w(102, 112, 0, 1)}};
    vecs[2] = '{0, 4'b0100, {16'h0, 16'h20, 16'h0, 16'h0}, 8'd250, 8'd50, 8'd8, 8'd8, 3, 1,
                {18'h0, w(255, 42, 0, 1)}};
    vecs[3] = '{0, 4'b1000, {16'h30, 16'h0, 16'h0, 16'h0}, 8'd2, 8'd3, 8'd8, 8'd8, 3, 1,
                {18'h0, w(0, 0, 0, 1)}};
    vecs[4] = '{0, 4'b0011, {16'h0, 16'h0, 16'h30, 16'h20}, 8'd100, 8'd100, 8'd0, 8'd0, 4, 2,
                {w(100, 100, 0, 1), w(120, 100, 0, 1)}};
    vecs[5] = '{1, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h20}, 8'd250, 8'd50, 8'd8, 8'd8, 3, 1,
                {18'h0, w(200, 42, 0, 1)}};
    vecs[6] = '{1, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h30}, 8'd2, 8'd3, 8'd8, 8'd8, 3, 1,
                {18'h0, w(16, 16, 0, 1)}};
    vecs[7] = '{1, 4'b0000, 64'h0, 8'd0, 8'd0, 8'd0, 8'd0, 2, 0, 36'h0};

    rst = 1'b1;
    b0.start = 1'b0;
    b1.start = 1'b0;
    set_obj(0, 4'b0, 64'h0, 8'd0, 8'd0, 8'd0, 8'd0);
    set_obj(1, 4'b0, 64'h0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(b0.busy), 32'd0);
    chk("rst_done", 32'(b0.done), 32'd0);
    chk("rst_ovf", 32'(b0.overflow), 32'd0);
    chk("rst_we", 32'(b0.weWRITE), 32'd0);
    chk("rst_wc", 32'(b0.word_count), 32'd0);
    chk("rst_adrrom", 32'(b0.adrROM), 32'd0);
    chk("rst_adrwr", 32'(b0.adrWRITE), 32'd0);
    chk("rst_datawr", 32'(b0.dataWRITE), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      set_obj(vecs[v].inst, vecs[v].en, vecs[v].adr, vecs[v].x, vecs[v].y, vecs[v].mx, vecs[v].my);
      run_build(vecs[v].inst, $sformatf("v%0d", v), vecs[v].wc, base);
      for (int k = 0; k < vecs[v].npts; k++)
        chk_word(vecs[v].inst, base + 1 + k, k + 1, vecs[v].pt[k], $sformatf("v%0d_pt%0d", v, k));
      chk($sformatf("v%0d_ovf", v), 32'(vecs[v].inst == 0 ? b0.overflow : b1.overflow), 32'd0);
    end

    // Overflow: 10 points into an 8-word RAM, then a clean build clears the flag.
    set_obj(1, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h40}, 8'd20, 8'd20, 8'd0, 8'd0);
    run_build(1, "ovf", 8, base);
    for (int k = 0; k < 6; k++)
      chk_word(1, base + 1 + k, k + 1, w(20 + 10 * k, 20 + 5 * k, 1, 0), $sformatf("ovf_pt%0d", k));
    chk("ovf_flag", 32'(b1.overflow), 32'd1);
    if (log_size(1) > base + 2) chk("ovf_lat3_spacing", 32'(wlog1[base + 2].cy - wlog1[base + 1].cy), 32'd4);
    else chk("ovf_lat3_spacing_missing", 32'(log_size(1)), 32'(base + 3));
    set_obj(1, 4'b0000, 64'h0, 8'd0, 8'd0, 8'd0, 8'd0);
    run_build(1, "ovf_clr", 2, base);
    chk("ovf_cleared", 32'(b1.overflow), 32'd0);

    // Snapshot: inputs change and a second start arrives mid-build.
    set_obj(0, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h10}, 8'd100, 8'd100, 8'd8, 8'd8);
    base = log_size(0);
    n = done0;
    pulse_start(0);
    repeat (3) @(negedge clk);
    b0.obj_x = {4{8'd50}};
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    wait_done(0, "snap");
    repeat (20) @(negedge clk);
    chk("snap_done_cnt", 32'(done0 - n), 32'd1);
    chk("snap_strobes", 32'(log_size(0) - base), 32'd4);
    chk_word(0, base + 1, 1, w(102, 112, 0, 1), "snap_pt0");
    chk_word(0, base + 2, 2, w(122, 112, 1, 0), "snap_pt1");
    if (log_size(0) > base + 2) chk("snap_lat1_spacing", 32'(wlog0[base + 2].cy - wlog0[base + 1].cy), 32'd2);
    else chk("snap_lat1_spacing_missing", 32'(log_size(0)), 32'(base + 3));

    // Reset while slot 1 is streaming.
    set_obj(0, 4'b0011, {16'h0, 16'h0, 16'h40, 16'h10}, 8'd20, 8'd20, 8'd0, 8'd0);
    pulse_start(0);
    n = 0;
    while (b0.adrROM != 16'h0043 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach_slot1", 32'(b0.adrROM), 32'h43);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_we", 32'(b0.weWRITE), 32'd0);
    chk("mid_busy", 32'(b0.busy), 32'd0);
    chk("mid_done", 32'(b0.done), 32'd0);
    chk("mid_adrrom", 32'(b0.adrROM), 32'd0);
    chk("mid_adrwr", 32'(b0.adrWRITE), 32'd0);
    chk("mid_datawr", 32'(b0.dataWRITE), 32'd0);
    chk("mid_wc", 32'(b0.word_count), 32'd0);
    rst = 1'b0;
    base = log_size(0);
    repeat (10) @(negedge clk);
    chk("mid_no_writes", 32'(log_size(0) - base), 32'd0);
    set_obj(0, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h10}, 8'd100, 8'd100, 8'd8, 8'd8);
    run_build(0, "post_rst", 4, base);
    chk_word(0, base + 1, 1, w(102, 112, 0, 1), "post_rst_pt0");
    chk_word(0, base + 2, 2, w(122, 112, 1, 0), "post_rst_pt1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
